// File: rtl/spi_master_ctrl_if.sv
// Command/response and SPI pin bundle for the host-side SPI master.
// The master modport is the controller; the slave modport is its host/peer side.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_byte;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_op, cmd_byte, MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_byte, MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: serialises one RAM command per request on SS_n/MOSI
// and returns READ data captured from MISO.
module spi_master_ctrl #(
  parameter int unsigned RD_WAIT = 6,
  parameter int unsigned WR_TAIL = 2,
  parameter int unsigned GAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);

  localparam int unsigned MAX_TW = (RD_WAIT > WR_TAIL) ? RD_WAIT : WR_TAIL;
  localparam int unsigned CNT_MAX = (MAX_TW > GAP) ? MAX_TW : GAP;
  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_TAIL,
    S_WAIT,
    S_CAPTURE,
    S_GAP
  } state_e;

  state_e        state_q;
  logic [1:0]    op_q;
  logic [10:0]   tx_q;
  logic [6:0]    rx_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic          ss_n_q;
  logic          mosi_q;
  logic          busy_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    bit_inc;

  // Both counters saturate instead of wrapping.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    bit_inc = (bit_q == '1) ? bit_q : bit_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            tx_q    <= {bus.cmd_op[1], bus.cmd_op, bus.cmd_byte};
            ss_n_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          mosi_q  <= tx_q[10];
          tx_q    <= {tx_q[9:0], 1'b0};
          bit_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bit_q == 4'd10) begin
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= (op_q == 2'b11) ? S_WAIT : S_TAIL;
          end else begin
            mosi_q <= tx_q[10];
            tx_q   <= {tx_q[9:0], 1'b0};
            bit_q  <= bit_inc;
          end
        end
        S_TAIL: begin
          if (cnt_q == CW'(WR_TAIL - 1)) begin
            ss_n_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_WAIT: begin
          if (cnt_q == CW'(RD_WAIT - 1)) begin
            bit_q   <= '0;
            rx_q    <= '0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_CAPTURE: begin
          // The eighth sample goes straight into rsp_data alongside the pulse.
          rx_q <= {rx_q[5:0], bus.MISO};
          if (bit_q == 4'd7) begin
            rsp_data_q  <= {rx_q, bus.MISO};
            rsp_valid_q <= 1'b1;
            ss_n_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_GAP;
          end else begin
            bit_q <= bit_inc;
          end
        end
        S_GAP: begin
          if (cnt_q == CW'(GAP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI RAM slave on the pins.
module tb_spi_master_ctrl;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(.RD_WAIT(6), .WR_TAIL(2), .GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame monitor and RAM slave model, sampled on negedge.
  int          low_cnt    = 0;
  int          hi_cnt     = 0;
  int          last_len   = 0;
  int          last_gap   = 0;
  int          frames     = 0;
  int          rsp_pulses = 0;
  logic [25:0] mosi_sr    = '0;
  logic [25:0] last_mosi  = '0;
  logic [7:0]  wr_addr    = '0;
  logic [7:0]  rd_addr    = '0;
  logic [7:0]  miso_byte  = '0;
  logic [7:0]  mem [256];

  always @(negedge clk) begin
    if (bus.SS_n === 1'b0) begin
      if (hi_cnt != 0) last_gap = hi_cnt;
      hi_cnt  = 0;
      mosi_sr = {mosi_sr[24:0], bus.MOSI};
      if (low_cnt == 11) begin
        case (mosi_sr[10:8])
          3'b000:  wr_addr = mosi_sr[7:0];
          3'b001:  mem[wr_addr] = mosi_sr[7:0];
          3'b110:  rd_addr = mosi_sr[7:0];
          3'b111:  miso_byte = mem[rd_addr];
          default: ;
        endcase
      end
      if (low_cnt >= 18 && low_cnt <= 25) bus.MISO = miso_byte[25-low_cnt];
      low_cnt++;
    end else begin
      if (low_cnt != 0) begin
        last_len  = low_cnt;
        last_mosi = mosi_sr;
        frames++;
      end
      low_cnt  = 0;
      mosi_sr  = '0;
      bus.MISO = 1'b0;
      hi_cnt++;
    end
    if (bus.rsp_valid === 1'b1) rsp_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] b);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_byte  = b;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: cmd_ready never rose, op=%0d", op);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_byte  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL busy_timeout: busy still %b after 200 cycles", bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_byte = '0;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", bus.SS_n); end
    n_chk++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", bus.MOSI); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_chk++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_write_a();
    int f0 = frames;
    int p0 = rsp_pulses;
    send(2'b00, 8'h5A);
    n_chk++; if (bus.busy !== 1'b1 || bus.SS_n !== 1'b0) begin n_fail++; $display("FAIL wra_start: busy=%b SS_n=%b want 1/0", bus.busy, bus.SS_n); end
    wait_idle();
    n_chk++; if (frames != f0 + 1) begin n_fail++; $display("FAIL wra_frames: got %0d want %0d", frames, f0 + 1); end
    n_chk++; if (last_len != 14) begin n_fail++; $display("FAIL wra_len: got %0d want 14", last_len); end
    n_chk++; if (last_mosi[13:0] !== 14'b0_000_01011010_00) begin n_fail++; $display("FAIL wra_mosi: got %b want 00000101101000", last_mosi[13:0]); end
    n_chk++; if (rsp_pulses != p0) begin n_fail++; $display("FAIL wra_no_rsp: got %0d pulses want %0d", rsp_pulses, p0); end
  endtask

  task automatic test_read();
    int p0;
    send(2'b00, 8'h10); wait_idle();
    send(2'b01, 8'hC3); wait_idle();
    send(2'b10, 8'h10); wait_idle();
    p0 = rsp_pulses;
    send(2'b11, 8'hA7);
    wait_idle();
    n_chk++; if (last_len != 26) begin n_fail++; $display("FAIL rd_len: got %0d want 26", last_len); end
    n_chk++; if (last_mosi !== {1'b0, 3'b111, 8'hA7, 14'b0}) begin n_fail++; $display("FAIL rd_mosi: got %b", last_mosi); end
    n_chk++; if (bus.rsp_data !== 8'hC3) begin n_fail++; $display("FAIL rd_data: got %h want c3", bus.rsp_data); end
    n_chk++; if (rsp_pulses != p0 + 1) begin n_fail++; $display("FAIL rd_pulse: got %0d cycles want 1", rsp_pulses - p0); end
    send(2'b01, 8'h77); wait_idle();
    n_chk++; if (bus.rsp_data !== 8'hC3) begin n_fail++; $display("FAIL rd_hold: got %h want c3", bus.rsp_data); end
  endtask

  task automatic test_back_to_back();
    int f0 = frames;
    int n  = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_byte = 8'h11;
    while (frames < f0 + 2 && n < 200) begin tick(); n++; end
    bus.cmd_valid = 1'b0;
    n_chk++; if (n >= 200) begin n_fail++; $display("FAIL b2b_timeout: frames %0d want %0d", frames - f0, 2); end
    n_chk++; if (last_gap != 2) begin n_fail++; $display("FAIL b2b_gap: SS_n high %0d cycles want 2", last_gap); end
    wait_idle();
    repeat (3) tick();
    n_chk++; if (frames != f0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d frames want 2", frames - f0); end
    f0 = frames;
    send(2'b00, 8'h22);
    repeat (3) tick();
    n_chk++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy: got %b want 0", bus.cmd_ready); end
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_byte = 8'hFF;
    tick();
    bus.cmd_valid = 1'b0;
    wait_idle();
    repeat (5) tick();
    n_chk++; if (frames != f0 + 1) begin n_fail++; $display("FAIL b2b_dropped: got %0d frames want 1", frames - f0); end
  endtask

  task automatic test_reset_abort();
    int p0 = rsp_pulses;
    send(2'b11, 8'h55);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL abort_ss_n: got %b want 1", bus.SS_n); end
    n_chk++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL abort_mosi: got %b want 0", bus.MOSI); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    repeat (30) tick();
    n_chk++; if (rsp_pulses != p0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d pulses want 0", rsp_pulses - p0); end
    n_chk++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL abort_rsp_data: got %h want 00", bus.rsp_data); end
    send(2'b01, 8'h3C);
    wait_idle();
    n_chk++; if (last_len != 14) begin n_fail++; $display("FAIL abort_next_len: got %0d want 14", last_len); end
    n_chk++; if (last_mosi[13:0] !== 14'b0_001_00111100_00) begin n_fail++; $display("FAIL abort_next_mosi: got %b want 00010011110000", last_mosi[13:0]); end
  endtask

  task automatic test_ram_random();
    int f0 = frames;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      a = 8'($urandom);
      d = 8'($urandom);
      send(2'b00, a);           wait_idle();
      send(2'b01, d);           wait_idle();
      send(2'b10, a);           wait_idle();
      send(2'b11, 8'($urandom)); wait_idle();
      n_chk++;
      if (bus.rsp_data !== d) begin
        n_fail++;
        $display("FAIL ram_rd[%0d]: addr %h got %h want %h", i, a, bus.rsp_data, d);
      end
    end
    n_chk++; if (frames != f0 + 400) begin n_fail++; $display("FAIL ram_frames: got %0d want 400", frames - f0); end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read();
    test_back_to_back();
    test_reset_abort();
    test_ram_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
